hud_gen: RTL
============

HUD_GEN -- requirements
Module: hud_gen

Interface
REQ-001 SHALL have parameter SCORE_DIGITS, default 3, giving the number of BCD digits for score and hi-score (legal range 1..5).
REQ-002 SHALL have parameter BLINK_BITS, default 24, giving the width of the subtitle blink timer.
REQ-003 SHALL have parameter FG_COLOR, default 6'b110000, giving the lit-glyph colour.
REQ-004 SHALL have parameter BG_COLOR, default 6'b000000, giving the unlit/background colour.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port state, input, 2 bits: game state, encoded MENU=0, PLAYING=1, DEAD=2, WIN=3.
REQ-008 SHALL have port level, input, 4 bits: current level, 0..15.
REQ-009 SHALL have port score_inc, input, 1 bit: one-cycle pulse meaning the frog reached a new row.
REQ-010 SHALL have ports colPos and rowPos, inputs, 10 bits each: current VGA pixel.
REQ-011 SHALL have port color, output, 6 bits: overlay pixel colour.
REQ-012 SHALL have port pix_on, output, 1 bit: high when color is a lit glyph pixel.
REQ-013 SHALL have port hiscore_bcd, output, 4*SCORE_DIGITS bits: registered hi-score, for debug.

Function
REQ-014 SHALL keep the score as a BCD counter; no divide or modulo operators are permitted.
REQ-015 SHALL increment the score by 1 on a clock with score_inc=1 and state=PLAYING; score_inc in any other state is ignored.
REQ-016 SHALL saturate the score at all-9s; further increments have no effect.
REQ-017 SHALL clear the score on any clock with state=MENU; this clear has priority over score_inc.
REQ-018 SHALL leave the hi-score untouched by MENU; the hi-score is cleared only by rst_n.
REQ-019 SHALL load the incremented score into the hi-score on the same clock edge whenever the incremented score exceeds the hi-score (BCD magnitude compare).
REQ-020 SHALL render HUD fields at 2x scale with a 5 px inset from the top edge.
REQ-021 SHALL render the left field as "PTS:" + score digits + " HI:" + hi-score digits, starting at x=101.
REQ-022 SHALL render the right field as "LVL:" + two decimal digits (00..15), right-aligned to end at x=539.
REQ-023 SHALL render the state banner at 7x scale, horizontally centred, top at y=155.
REQ-024 SHALL select the banner text by state: MENU "FROGGER", DEAD "GAME OVER", WIN "YOU WIN", PLAYING none.
REQ-025 SHALL render the subtitle "PRESS ANY KEY" at 2x scale, centred, top at y=330, in the MENU, DEAD and WIN states only, gated by the blink flag.
REQ-026 SHALL make the blink timer a free-running BLINK_BITS counter, toggling the blink flag when the counter wraps to 0.
REQ-027 SHALL give HUD fields priority over the banner, and the banner priority over the subtitle.
REQ-028 SHALL pipeline the pixel path in two stages, so colPos/rowPos sampled at edge N produce color and pix_on after edge N+2.
REQ-029 SHALL use stage 1 to register the field hit, character code, glyph row and glyph column, computing the scale with constant shifts and compares only.
REQ-030 SHALL use stage 2 to register the font bitmap bit from text_gen.
REQ-031 SHALL output color = FG_COLOR when pix_on=1, else BG_COLOR.
REQ-032 SHALL output BG_COLOR for every pixel outside all active fields.

Reset
REQ-033 SHALL, while rst_n=0, hold score=0, hi-score=0, blink timer=0, blink flag=1, both pipeline stages cleared, color=BG_COLOR and pix_on=0.
REQ-034 SHALL assert reset asynchronously and release it synchronously, so the first update occurs at the first clk edge with rst_n=1.
REQ-035 SHALL, on reset mid-frame, drop the in-flight pipeline contents; no stale lit pixel may emerge after release.

Verification
REQ-036 SHALL cover: state=PLAYING, 12 score_inc pulses -> score digits read "012"; return to MENU -> score "000", hiscore_bcd=12.
REQ-037 SHALL cover: SCORE_DIGITS=2, 105 pulses in PLAYING -> score holds at 99, hiscore_bcd=99.
REQ-038 SHALL cover: score_inc asserted on the same clock that state enters MENU -> score=0, hi-score unchanged.
REQ-039 SHALL cover: a pixel on a lit "F" glyph of the MENU banner applied at edge N -> pix_on=1 and color=6'b110000 exactly at edge N+2, and 0 at N+1.
REQ-040 SHALL cover: BLINK_BITS=4 -> the subtitle region toggles visibility every 16 clocks; in state=PLAYING the subtitle region is always BG_COLOR.
REQ-041 SHALL cover: rst_n pulsed low mid-line after a hiscore of 7 -> hiscore_bcd=0, color=BG_COLOR immediately, and the next two clocks output BG_COLOR.

Source files
------------

// File: rtl/hud_gen.sv
// hud_gen: BCD score / hi-score keeping and a two-stage text overlay
// for the HUD line, the state banner and the blinking subtitle.
module hud_gen #(
  parameter int         SCORE_DIGITS = 3,
  parameter int         BLINK_BITS   = 24,
  parameter logic [5:0] FG_COLOR     = 6'b110000,
  parameter logic [5:0] BG_COLOR     = 6'b000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                state,
  input  logic [3:0]                level,
  input  logic                      score_inc,
  input  logic [9:0]                colPos,
  input  logic [9:0]                rowPos,
  output logic [5:0]                color,
  output logic                      pix_on,
  output logic [4*SCORE_DIGITS-1:0] hiscore_bcd
);
  localparam int SW = 4 * SCORE_DIGITS;
  localparam int LN = 8 + 2 * SCORE_DIGITS;

  localparam logic [1:0] ST_MENU = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;
  localparam logic [1:0] ST_WIN  = 2'd3;

  localparam logic [4:0] C_SP = 5'd10, C_CO = 5'd11, C_A = 5'd12;
  localparam logic [4:0] C_E  = 5'd13, C_F  = 5'd14, C_G = 5'd15;
  localparam logic [4:0] C_H  = 5'd16, C_I  = 5'd17, C_K = 5'd18;
  localparam logic [4:0] C_L  = 5'd19, C_M  = 5'd20, C_N = 5'd21;
  localparam logic [4:0] C_O  = 5'd22, C_P  = 5'd23, C_R = 5'd24;
  localparam logic [4:0] C_S  = 5'd25, C_T  = 5'd26, C_U = 5'd27;
  localparam logic [4:0] C_V  = 5'd28, C_W  = 5'd29, C_Y = 5'd30;

  // Element 0 is the leftmost character of each string.
  localparam logic [3:0][4:0] S_PTS = {C_CO, C_S, C_T, C_P};
  localparam logic [3:0][4:0] S_HI  = {C_CO, C_I, C_H, C_SP};
  localparam logic [3:0][4:0] S_LVL = {C_CO, C_L, C_V, C_L};
  localparam logic [6:0][4:0] S_FROG =
    {C_R, C_E, C_G, C_G, C_O, C_R, C_F};
  localparam logic [8:0][4:0] S_OVER =
    {C_R, C_E, C_V, C_O, C_SP, C_E, C_M, C_A, C_G};
  localparam logic [6:0][4:0] S_WIN =
    {C_N, C_I, C_W, C_SP, C_U, C_O, C_Y};
  localparam logic [12:0][4:0] S_SUB =
    {C_Y, C_E, C_K, C_SP, C_Y, C_N, C_A, C_SP, C_S, C_S, C_E, C_R, C_P};

  // Cells are 8x8 (5x7 glyph), so 2x scale is a 16 px pitch.
  localparam logic [9:0] HY0 = 10'd5,   HY1 = 10'd21;
  localparam logic [9:0] LX0 = 10'd101, LX1 = 10'(101 + 16 * LN);
  localparam logic [9:0] RX0 = 10'd444, RX1 = 10'd540;
  localparam logic [9:0] BY0 = 10'd155, BY1 = 10'd211;
  localparam logic [9:0] SY0 = 10'd330, SY1 = 10'd346;
  localparam logic [9:0] SX0 = 10'd216, SX1 = 10'd424;

  function automatic logic text_gen(
    input logic [4:0] c,
    input logic [2:0] r,
    input logic [2:0] k
  );
    logic [34:0] g;
    logic [5:0]  i;
    unique case (c)
      5'd0: g = 35'b01110_10001_10011_10101_11001_10001_01110;
      5'd1: g = 35'b00100_01100_00100_00100_00100_00100_01110;
      5'd2: g = 35'b01110_10001_00001_00010_00100_01000_11111;
      5'd3: g = 35'b11111_00010_00100_00010_00001_10001_01110;
      5'd4: g = 35'b00010_00110_01010_10010_11111_00010_00010;
      5'd5: g = 35'b11111_10000_11110_00001_00001_10001_01110;
      5'd6: g = 35'b00110_01000_10000_11110_10001_10001_01110;
      5'd7: g = 35'b11111_00001_00010_00100_01000_01000_01000;
      5'd8: g = 35'b01110_10001_10001_01110_10001_10001_01110;
      5'd9: g = 35'b01110_10001_10001_01111_00001_00010_01100;
      C_CO: g = 35'b00000_01100_01100_00000_01100_01100_00000;
      C_A:  g = 35'b01110_10001_10001_11111_10001_10001_10001;
      C_E:  g = 35'b11111_10000_10000_11110_10000_10000_11111;
      C_F:  g = 35'b11111_10000_10000_11110_10000_10000_10000;
      C_G:  g = 35'b01110_10001_10000_10111_10001_10001_01111;
      C_H:  g = 35'b10001_10001_10001_11111_10001_10001_10001;
      C_I:  g = 35'b01110_00100_00100_00100_00100_00100_01110;
      C_K:  g = 35'b10001_10010_10100_11000_10100_10010_10001;
      C_L:  g = 35'b10000_10000_10000_10000_10000_10000_11111;
      C_M:  g = 35'b10001_11011_10101_10101_10001_10001_10001;
      C_N:  g = 35'b10001_10001_11001_10101_10011_10001_10001;
      C_O:  g = 35'b01110_10001_10001_10001_10001_10001_01110;
      C_P:  g = 35'b11110_10001_10001_11110_10000_10000_10000;
      C_R:  g = 35'b11110_10001_10001_11110_10100_10010_10001;
      C_S:  g = 35'b01111_10000_10000_01110_00001_00001_11110;
      C_T:  g = 35'b11111_00100_00100_00100_00100_00100_00100;
      C_U:  g = 35'b10001_10001_10001_10001_10001_10001_01110;
      C_V:  g = 35'b10001_10001_10001_10001_10001_01010_00100;
      C_W:  g = 35'b10001_10001_10001_10101_10101_10101_01010;
      C_Y:  g = 35'b10001_10001_01010_00100_00100_00100_00100;
      default: g = '0;
    endcase
    if (r == 3'd7 || k > 3'd4) return 1'b0;
    i = 6'd34 - 6'(r) * 6'd5 - 6'(k);
    return g[i];
  endfunction

  // Divide by 7 for the banner scale using constant compares only.
  function automatic logic [6:0] div7(input logic [9:0] v);
    logic [6:0] q;
    q = '0;
    for (int k = 1; k < 72; k++)
      if (v >= 10'(7 * k)) q = q + 7'd1;
    return q;
  endfunction

  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic c, sat;
    r = v;
    c = 1'b1;
    sat = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) sat = 1'b0;
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return sat ? v : r;
  endfunction

  logic [SW-1:0]         score_q, score_d, hi_q, hi_d, inc_v;
  logic [BLINK_BITS-1:0] bcnt_q, bcnt_d;
  logic                  blink_q, blink_d;
  logic                  s1_hit_q, s1_hit_d;
  logic [4:0]            s1_code_q, s1_code_d;
  logic [2:0]            s1_row_q, s1_row_d, s1_col_q, s1_col_d;
  logic                  pix_q, pix_d;
  logic [9:0]            loff, roff, boff, soff, hoff, svoff;
  logic [9:0]            bx0, bx1;
  logic [6:0]            bu, brow;
  logic [5:0]            li, lj, ri, si;
  logic [3:0]            bi, tens, ones;
  logic                  in_l, in_r, in_b, in_s;

  always_comb begin
    inc_v   = bcd_inc(score_q);
    score_d = score_q;
    hi_d    = hi_q;
    if (state == ST_MENU) begin
      score_d = '0;
    end else if (score_inc && state == ST_PLAY) begin
      score_d = inc_v;
      if (inc_v > hi_q) hi_d = inc_v;
    end
    bcnt_d  = bcnt_q + BLINK_BITS'(1);
    blink_d = (bcnt_d == '0) ? ~blink_q : blink_q;
  end

  always_comb begin
    hoff  = rowPos - HY0;
    svoff = rowPos - SY0;
    loff  = colPos - LX0;
    roff  = colPos - RX0;
    soff  = colPos - SX0;
    bx0   = (state == ST_DEAD) ? 10'd68 : 10'd124;
    bx1   = (state == ST_DEAD) ? 10'd572 : 10'd516;
    boff  = colPos - bx0;
    bu    = div7(boff);
    brow  = div7(rowPos - BY0);
    li    = 6'(loff >> 4);
    lj    = li - 6'(4 + SCORE_DIGITS);
    ri    = 6'(roff >> 4);
    si    = 6'(soff >> 4);
    bi    = 4'(bu >> 3);
    tens  = (level >= 4'd10) ? 4'd1 : 4'd0;
    ones  = (level >= 4'd10) ? level - 4'd10 : level;
    in_l  = rowPos >= HY0 && rowPos < HY1 &&
            colPos >= LX0 && colPos < LX1;
    in_r  = rowPos >= HY0 && rowPos < HY1 &&
            colPos >= RX0 && colPos < RX1;
    in_b  = state != ST_PLAY &&
            rowPos >= BY0 && rowPos < BY1 &&
            colPos >= bx0 && colPos < bx1;
    in_s  = state != ST_PLAY && blink_q &&
            rowPos >= SY0 && rowPos < SY1 &&
            colPos >= SX0 && colPos < SX1;

    s1_hit_d  = 1'b0;
    s1_code_d = C_SP;
    s1_row_d  = '0;
    s1_col_d  = '0;
    if (in_l) begin
      s1_hit_d = 1'b1;
      s1_row_d = 3'(hoff >> 1);
      s1_col_d = 3'(loff >> 1);
      if (li < 6'd4) s1_code_d = S_PTS[2'(li)];
      else           s1_code_d = S_HI[2'(lj)];
      for (int i = 0; i < SCORE_DIGITS; i++) begin
        if (li == 6'(3 + SCORE_DIGITS - i))
          s1_code_d = {1'b0, score_q[4*i +: 4]};
        if (li == 6'(7 + 2 * SCORE_DIGITS - i))
          s1_code_d = {1'b0, hi_q[4*i +: 4]};
      end
    end else if (in_r) begin
      s1_hit_d = 1'b1;
      s1_row_d = 3'(hoff >> 1);
      s1_col_d = 3'(roff >> 1);
      if (ri == 6'd4)      s1_code_d = {1'b0, tens};
      else if (ri == 6'd5) s1_code_d = {1'b0, ones};
      else                 s1_code_d = S_LVL[2'(ri)];
    end else if (in_b) begin
      s1_hit_d = 1'b1;
      s1_row_d = 3'(brow);
      s1_col_d = 3'(bu);
      unique case (state)
        ST_DEAD: s1_code_d = S_OVER[bi];
        ST_WIN:  s1_code_d = S_WIN[3'(bi)];
        default: s1_code_d = S_FROG[3'(bi)];
      endcase
    end else if (in_s) begin
      s1_hit_d  = 1'b1;
      s1_row_d  = 3'(svoff >> 1);
      s1_col_d  = 3'(soff >> 1);
      s1_code_d = S_SUB[4'(si)];
    end
  end

  always_comb begin
    pix_d = s1_hit_q && text_gen(s1_code_q, s1_row_q, s1_col_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q   <= '0;
      hi_q      <= '0;
      bcnt_q    <= '0;
      blink_q   <= 1'b1;
      s1_hit_q  <= 1'b0;
      s1_code_q <= '0;
      s1_row_q  <= '0;
      s1_col_q  <= '0;
      pix_q     <= 1'b0;
    end else begin
      score_q   <= score_d;
      hi_q      <= hi_d;
      bcnt_q    <= bcnt_d;
      blink_q   <= blink_d;
      s1_hit_q  <= s1_hit_d;
      s1_code_q <= s1_code_d;
      s1_row_q  <= s1_row_d;
      s1_col_q  <= s1_col_d;
      pix_q     <= pix_d;
    end
  end

  assign pix_on      = pix_q;
  assign color       = pix_q ? FG_COLOR : BG_COLOR;
  assign hiscore_bcd = hi_q;

endmodule
